// File: rtl/minmax_job_arbiter.sv
// Two-requester job arbiter/sequencer in front of a shared min/max search engine.
// Optional engine watchdog: define MINMAX_ARB_TIMEOUT_EN.
module minmax_job_arbiter #(
  parameter int TO_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid_a,
  input  logic       req_valid_b,
  input  logic [3:0] req_addr_a,
  input  logic [3:0] req_addr_b,
  input  logic [4:0] req_data_a,
  input  logic [4:0] req_data_b,
  input  logic       req_last_a,
  input  logic       req_last_b,
  output logic       req_ready_a,
  output logic       req_ready_b,
  output logic       rsp_valid_a,
  output logic       rsp_valid_b,
  input  logic       rsp_ready_a,
  input  logic       rsp_ready_b,
  output logic [3:0] rsp_max_addr,
  output logic [4:0] rsp_max,
  output logic [4:0] rsp_min,
  output logic       rsp_ovf,
  output logic       rsp_err,
  output logic       eng_s_vi,
  output logic       eng_takein,
  output logic [3:0] eng_ai,
  output logic [4:0] eng_di,
  input  logic [3:0] eng_ao,
  input  logic [4:0] eng_do,
  input  logic [4:0] eng_do_min,
  input  logic       eng_vo,
  output logic       busy,
  output logic       owner
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0] state;
  logic       rr;
  logic [4:0] cnt;

  logic       b_valid;
  logic       b_last;
  logic [3:0] b_addr;
  logic [4:0] b_data;
  logic       acc;
  logic       fin;
  logic       rsp_done;
  logic       to_hit;

  // Owner's beat lane
  always_comb begin
    b_valid = req_valid_a;
    b_last  = req_last_a;
    b_addr  = req_addr_a;
    b_data  = req_data_a;
    if (owner) begin
      b_valid = req_valid_b;
      b_last  = req_last_b;
      b_addr  = req_addr_b;
      b_data  = req_data_b;
    end
  end

  assign acc = (state == S_LOAD) && b_valid;
  assign fin = acc && (b_last || (cnt == 5'd15));

  assign rsp_done = (state == S_RESP) &&
                    (owner ? rsp_ready_b : rsp_ready_a);

  assign busy        = (state != S_IDLE);
  assign eng_takein  = busy;
  assign req_ready_a = (state == S_LOAD) && !owner;
  assign req_ready_b = (state == S_LOAD) && owner;
  assign rsp_valid_a = (state == S_RESP) && !owner;
  assign rsp_valid_b = (state == S_RESP) && owner;

`ifdef MINMAX_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TO_CYCLES - 1);

  logic [7:0] to_cnt;

  always_ff @(posedge clk) begin
    if (rst || (state != S_RUN)) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 8'd1;
    end
  end

  assign to_hit = (state == S_RUN) && !eng_vo &&
                  (to_cnt == TO_LIM);
`else
  // No watchdog in this build: an error can never be raised
  assign to_hit = (TO_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      rr           <= 1'b0;
      owner        <= 1'b0;
      cnt          <= '0;
      eng_s_vi     <= 1'b0;
      eng_ai       <= '0;
      eng_di       <= '0;
      rsp_max_addr <= '0;
      rsp_max      <= '0;
      rsp_min      <= '0;
      rsp_ovf      <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid_a || req_valid_b) begin
            owner   <= (req_valid_a && req_valid_b) ? rr
                                                    : req_valid_b;
            cnt     <= '0;
            rsp_ovf <= 1'b0;
            rsp_err <= 1'b0;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          eng_s_vi <= acc;
          if (acc) begin
            eng_ai <= b_addr;
            eng_di <= b_data;
            cnt    <= cnt + 5'd1;
          end
          if (fin) begin
            rsp_ovf <= !b_last;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          eng_s_vi <= 1'b0;
          if (eng_vo) begin
            rsp_max_addr <= eng_ao;
            rsp_max      <= eng_do;
            rsp_min      <= eng_do_min;
            state        <= S_RESP;
          end else if (to_hit) begin
            rsp_max_addr <= '0;
            rsp_max      <= '0;
            rsp_min      <= '0;
            rsp_err      <= 1'b1;
            state        <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_done) begin
            rr    <= ~owner;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_minmax_job_arbiter.sv
// Scoreboard bench for minmax_job_arbiter with a behavioural min/max engine.
// Watchdog case runs only when MINMAX_ARB_TIMEOUT_EN is defined.
module tb_minmax_job_arbiter;

  localparam int TO_CYC = 20;

  typedef struct {
    bit         own;
    logic [3:0] ma;
    logic [4:0] mx;
    logic [4:0] mn;
    bit         ovf;
    bit         err;
  } exp_t;

  typedef logic [3:0] a_arr_t [16];
  typedef logic [4:0] d_arr_t [16];

  logic       clk = 0;
  logic       rst = 1;
  logic       req_valid_a = 0, req_valid_b = 0;
  logic [3:0] req_addr_a = 0, req_addr_b = 0;
  logic [4:0] req_data_a = 0, req_data_b = 0;
  logic       req_last_a = 0, req_last_b = 0;
  logic       req_ready_a, req_ready_b;
  logic       rsp_valid_a, rsp_valid_b;
  logic       rsp_ready_a = 1, rsp_ready_b = 1;
  logic [3:0] rsp_max_addr;
  logic [4:0] rsp_max, rsp_min;
  logic       rsp_ovf, rsp_err;
  logic       eng_s_vi, eng_takein;
  logic [3:0] eng_ai;
  logic [4:0] eng_di;
  logic [3:0] eng_ao = 0;
  logic [4:0] eng_do = 0, eng_do_min = 0;
  logic       eng_vo = 0;
  logic       busy, owner;

  int   n_chk = 0;
  int   n_bad = 0;
  exp_t sbq[$];

  minmax_job_arbiter #(.TO_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst(rst),
    .req_valid_a(req_valid_a), .req_valid_b(req_valid_b),
    .req_addr_a(req_addr_a), .req_addr_b(req_addr_b),
    .req_data_a(req_data_a), .req_data_b(req_data_b),
    .req_last_a(req_last_a), .req_last_b(req_last_b),
    .req_ready_a(req_ready_a), .req_ready_b(req_ready_b),
    .rsp_valid_a(rsp_valid_a), .rsp_valid_b(rsp_valid_b),
    .rsp_ready_a(rsp_ready_a), .rsp_ready_b(rsp_ready_b),
    .rsp_max_addr(rsp_max_addr), .rsp_max(rsp_max),
    .rsp_min(rsp_min), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
    .eng_s_vi(eng_s_vi), .eng_takein(eng_takein),
    .eng_ai(eng_ai), .eng_di(eng_di),
    .eng_ao(eng_ao), .eng_do(eng_do),
    .eng_do_min(eng_do_min), .eng_vo(eng_vo),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural engine: writes while s_vi, search on falling s_vi
  logic [4:0]  emem [16];
  logic [15:0] evld = '0;
  logic        prev_svi = 0;
  int          elat = 0;
  bit          eng_hang = 0;

  function automatic exp_t search_mem();
    exp_t r;
    bit   any;
    r   = '{0, 0, 0, 0, 0, 0};
    any = 0;
    for (int i = 0; i < 16; i++) begin
      if (evld[i]) begin
        if (!any || emem[i] > r.mx) begin
          r.mx = emem[i];
          r.ma = 4'(i);
        end
        if (!any || emem[i] < r.mn) r.mn = emem[i];
        any = 1;
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    prev_svi <= eng_s_vi;
    eng_vo   <= 1'b0;
    if (!eng_takein) evld <= '0;
    else if (eng_s_vi) begin
      emem[eng_ai] <= eng_di;
      evld[eng_ai] <= 1'b1;
    end
    if (prev_svi && !eng_s_vi && eng_takein) elat <= 3;
    else if (elat > 1) elat <= elat - 1;
    else if (elat == 1) begin
      elat <= 0;
      if (!eng_hang) begin
        eng_vo     <= 1'b1;
        eng_ao     <= search_mem().ma;
        eng_do     <= search_mem().mx;
        eng_do_min <= search_mem().mn;
      end
    end
  end

  task automatic check_rsp(input bit s);
    exp_t e;
    if (sbq.size() == 0) begin
      n_chk++;
      n_bad++;
      $display("FAIL rsp_unexp side=%0d got=rsp exp=none", s);
      return;
    end
    e = sbq.pop_front();
    chk("rsp_own", s, e.own);
    chk("rsp_max_addr", rsp_max_addr, e.ma);
    chk("rsp_max", rsp_max, e.mx);
    chk("rsp_min", rsp_min, e.mn);
    chk("rsp_ovf", rsp_ovf, e.ovf);
    chk("rsp_err", rsp_err, e.err);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid_a && rsp_ready_a) check_rsp(0);
      if (rsp_valid_b && rsp_ready_b) check_rsp(1);
    end
  end

  function automatic exp_t calc(input bit own, input int n,
                                input a_arr_t aa, input d_arr_t dd,
                                input bit ovf);
    exp_t e;
    e = '{own, aa[0], dd[0], dd[0], ovf, 0};
    for (int i = 1; i < n; i++) begin
      if (dd[i] > e.mx) begin
        e.mx = dd[i];
        e.ma = aa[i];
      end
      if (dd[i] < e.mn) e.mn = dd[i];
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge of the write cycle
  task automatic beat(input bit s, input logic [3:0] a,
                      input logic [4:0] d, input bit l,
                      output int waited);
    int t = 0;
    if (!s) begin
      req_valid_a = 1; req_addr_a = a;
      req_data_a = d;  req_last_a = l;
    end else begin
      req_valid_b = 1; req_addr_b = a;
      req_data_b = d;  req_last_b = l;
    end
    while (!(s ? req_ready_b : req_ready_a) && t < 400) begin
      @(negedge clk);
      t++;
    end
    waited = t;
    if (t >= 400) begin
      n_chk++;
      n_bad++;
      $display("FAIL beat_wait side=%0d got=timeout exp=ready", s);
    end
    @(negedge clk);
    chk("eng_s_vi", eng_s_vi, 1);
    chk("eng_ai", eng_ai, a);
    chk("eng_di", eng_di, d);
  endtask

  task automatic burst(input bit s, input int n, input bit lf,
                       input a_arr_t aa, input d_arr_t dd,
                       output int w0);
    int w;
    w0 = 0;
    for (int i = 0; i < n; i++) begin
      beat(s, aa[i], dd[i], lf && (i == n - 1), w);
      if (i == 0) w0 = w;
    end
    if (!s) req_valid_a = 0;
    else req_valid_b = 0;
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain", sbq.size(), 0);
  endtask

  a_arr_t a1, ca, cb, ob, sa, sb, ra, ta;
  d_arr_t d1, cda, cdb, odb, sda, sdb, rda, tda;

  initial begin
    int w, wa, wb;
    a1  = '{0: 4'd0, 1: 4'd15, 2: 4'd13, default: 4'd0};
    d1  = '{0: 5'd15, 1: 5'd28, 2: 5'd6, default: 5'd0};
    ca  = '{0: 4'd2, 1: 4'd5, default: 4'd0};
    cda = '{0: 5'd7, 1: 5'd30, default: 5'd0};
    cb  = '{0: 4'd1, 1: 4'd9, 2: 4'd4, default: 4'd0};
    cdb = '{0: 5'd3, 1: 5'd20, 2: 5'd11, default: 5'd0};
    for (int i = 0; i < 16; i++) begin
      ob[i]  = 4'(i);
      odb[i] = 5'((i * 7 + 3) % 32);
    end
    sa  = '{0: 4'd3, 1: 4'd8, 2: 4'd11, default: 4'd0};
    sda = '{0: 5'd12, 1: 5'd25, 2: 5'd1, default: 5'd0};
    sb  = '{0: 4'd7, default: 4'd0};
    sdb = '{0: 5'd14, default: 5'd0};
    ra  = '{0: 4'd10, 1: 4'd12, default: 4'd0};
    rda = '{0: 5'd17, 1: 5'd4, default: 5'd0};
    ta  = '{0: 4'd5, default: 4'd0};
    tda = '{0: 5'd5, default: 5'd0};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_rdy_a", req_ready_a, 0);
    chk("rst_rdy_b", req_ready_b, 0);
    chk("rst_vld_a", rsp_valid_a, 0);
    chk("rst_vld_b", rsp_valid_b, 0);
    chk("rst_svi", eng_s_vi, 0);
    chk("rst_takein", eng_takein, 0);
    chk("rst_ai", eng_ai, 0);
    chk("rst_di", eng_di, 0);
    chk("rst_rsp", {rsp_max_addr, rsp_max, rsp_min}, 0);
    chk("rst_flags", {rsp_ovf, rsp_err}, 0);
    rst = 0;
    repeat (2) @(negedge clk);

    // collision from reset: A first, then B
    sbq.push_back(calc(0, 2, ca, cda, 0));
    sbq.push_back(calc(1, 3, cb, cdb, 0));
    fork
      burst(0, 2, 1, ca, cda, wa);
      burst(1, 3, 1, cb, cdb, wb);
      begin
        @(negedge clk);
        chk("col1_rdy_a", req_ready_a, 1);
        chk("col1_rdy_b", req_ready_b, 0);
      end
    join
    drain();

    // single A burst with grant latency and s_vi fall
    sbq.push_back(calc(0, 3, a1, d1, 0));
    burst(0, 3, 1, a1, d1, w);
    chk("grant_lat", w, 1);
    @(negedge clk);
    chk("svi_fall", eng_s_vi, 0);
    chk("busy_run", busy, 1);
    drain();

    // second collision: B first
    sbq.push_back(calc(1, 3, cb, cdb, 0));
    sbq.push_back(calc(0, 2, ca, cda, 0));
    fork
      burst(0, 2, 1, ca, cda, wa);
      burst(1, 3, 1, cb, cdb, wb);
      begin
        @(negedge clk);
        chk("col2_rdy_a", req_ready_a, 0);
        chk("col2_rdy_b", req_ready_b, 1);
      end
    join
    drain();

    // B overflow at 16 beats, 17th beat waits for a new grant
    sbq.push_back(calc(1, 16, ob, odb, 1));
    sbq.push_back('{1, 4'd6, 5'd19, 5'd19, 0, 0});
    for (int i = 0; i < 16; i++) beat(1, ob[i], odb[i], 0, w);
    req_addr_b = 4'd6;
    req_data_b = 5'd19;
    req_last_b = 1;
    chk("ovf_no17", req_ready_b, 0);
    beat(1, 4'd6, 5'd19, 1, w);
    req_valid_b = 0;
    drain();

    // response stall with B pending
    sbq.push_back(calc(0, 3, sa, sda, 0));
    sbq.push_back(calc(1, 1, sb, sdb, 0));
    rsp_ready_a = 0;
    fork
      burst(0, 3, 1, sa, sda, wa);
      begin
        repeat (3) @(negedge clk);
        burst(1, 1, 1, sb, sdb, wb);
      end
      begin
        int t = 0;
        while (!rsp_valid_a && t < 100) begin
          @(negedge clk);
          t++;
        end
        chk("stall_seen", rsp_valid_a, 1);
        for (int i = 0; i < 10; i++) begin
          chk("stall_vld", rsp_valid_a, 1);
          chk("stall_bus", {rsp_max_addr, rsp_max, rsp_min},
              {4'd8, 5'd25, 5'd1});
          chk("stall_rdy_b", req_ready_b, 0);
          chk("stall_busy", busy, 1);
          @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready_a = 1;
      end
    join
    drain();

    // reset mid-burst
    beat(0, 4'd0, 5'd9, 0, w);
    beat(0, 4'd1, 5'd8, 0, w);
    rst = 1;
    req_valid_a = 0;
    @(negedge clk);
    chk("mrst_busy", busy, 0);
    chk("mrst_svi", eng_s_vi, 0);
    chk("mrst_vld", rsp_valid_a, 0);
    chk("mrst_rdy", req_ready_a, 0);
    rst = 0;
    repeat (8) @(negedge clk);
    sbq.push_back(calc(0, 2, ra, rda, 0));
    burst(0, 2, 1, ra, rda, w);
    chk("mrst_grant", w, 1);
    drain();

`ifdef MINMAX_ARB_TIMEOUT_EN
    eng_hang = 1;
    sbq.push_back('{0, 4'd0, 5'd0, 5'd0, 0, 1});
    burst(0, 1, 1, ta, tda, w);
    drain();
    eng_hang = 0;
    repeat (4) @(negedge clk);
`endif

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/minmax_job_arbiter.md
# minmax_job_arbiter

Two-requester arbiter and sequencer that shares one `MIN_MAX_ALGORITHM` engine, a 16×5-bit memory with max/min search, between requester A and requester B. It grants the engine to one requester for a whole load burst and streams that requester's (address, data) beats onto the engine load port. It then waits for the engine result and returns max address, max value and min value to the owning requester over a valid/ready response. It sits between the two client datapaths and the engine instance.

## Interface
Parameters:
- `TO_CYCLES`, 255: engine watchdog limit in cycles. Used only when `MINMAX_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid_a`, `req_valid_b` in 1: load beat valid, per requester.
- `req_addr_a`, `req_addr_b` in 4: beat memory address.
- `req_data_a`, `req_data_b` in 5: beat data.
- `req_last_a`, `req_last_b` in 1: final beat of the burst.
- `req_ready_a`, `req_ready_b` out 1: beat accepted when valid & ready.
- `rsp_valid_a`, `rsp_valid_b` out 1: result valid for that requester.
- `rsp_ready_a`, `rsp_ready_b` in 1: result consumed.
- `rsp_max_addr` out 4, `rsp_max` out 5, `rsp_min` out 5: shared result bus.
- `rsp_ovf` out 1: burst was truncated at 16 beats.
- `rsp_err` out 1: watchdog abort.
- `eng_s_vi` out 1, `eng_takein` out 1, `eng_ai` out 4, `eng_di` out 5: drive the engine load port.
- `eng_ao` in 4, `eng_do` in 5, `eng_do_min` in 5, `eng_vo` in 1: engine result.
- `busy` out 1: state ≠ IDLE.
- `owner` out 1: 0 = A, 1 = B; valid while `busy`.

## Operation
Engine contract:
- Each cycle with `eng_s_vi`=1 writes `eng_di` to `eng_ai`.
- The falling `eng_s_vi` starts the search.
- `eng_vo`=1 marks `eng_ao`/`eng_do`/`eng_do_min` valid.

FSM states: IDLE, LOAD, RUN, RESP.
- **IDLE**
  - If any `req_valid` is high, select the owner: only one valid → that requester; both valid → requester named by the round-robin pointer `rr`.
  - Go to LOAD and clear the beat counter `cnt` (5-bit).
- **LOAD**
  - `req_ready_<owner>`=1. The other requester's ready = 0.
  - Each accepted beat registers `eng_s_vi`=1, `eng_ai`, `eng_di` for the next cycle and increments `cnt`.
  - A cycle with no beat registers `eng_s_vi`=0 (a gap in the load).
  - The beat with `req_last`=1, or the 16th beat, is the last beat. The 16th beat without `req_last` sets the `ovf` flag.
  - The last beat moves the FSM to RUN.
- **RUN**
  - `eng_s_vi`=0.
  - On `eng_vo`=1, capture `eng_ao`/`eng_do`/`eng_do_min` into the `rsp_*` registers and go to RESP.
- **RESP**
  - `rsp_valid_<owner>`=1 and the `rsp_*` outputs are held stable.
  - On `rsp_ready_<owner>`, go to IDLE and set `rr` = ~owner.
- `eng_takein` = 1 whenever not in IDLE.
- Beats presented by the non-owner are not accepted and stay pending until it is granted.

## Timing
- Reset values:
  - FSM = IDLE, `rr` = A (0), `owner` = 0, `cnt` = 0.
  - All ready/valid outputs = 0.
  - `eng_s_vi` = 0, `eng_takein` = 0, `eng_ai` = 0, `eng_di` = 0.
  - `rsp_*` = 0, `rsp_ovf` = 0, `rsp_err` = 0, `busy` = 0.
- Reset asserted mid-burst or mid-RUN aborts the job the next edge: all outputs return to reset values and no response is issued.
- Grant latency: request seen in IDLE at edge N → `req_ready` high during cycle N+1.
- Beat accepted at edge N → visible on `eng_*` during cycle N+1.
- `eng_s_vi` falls in the cycle after the last beat's write cycle.
- Result: `eng_vo` sampled at edge M → `rsp_valid` high from cycle M+1.
- After the response handshake at edge K → IDLE during cycle K+1. A new grant has `req_ready` high no earlier than K+2.
- A pending requester waits at most one full job.
- `rsp_ovf`/`rsp_err` are valid with `rsp_valid` and cleared when the next job is granted.

## Configuration
- `MINMAX_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter runs in RUN.
  - If `eng_vo` has not arrived after `TO_CYCLES` cycles in RUN, go to RESP with `rsp_err`=1 and `rsp_max_addr`/`rsp_max`/`rsp_min` = 0.
- Undefined:
  - No counter; RUN waits indefinitely.
  - `rsp_err` is constant 0.

## Test plan
- Reset, then A sends beats (0,15), (15,28), (13,6 last) → `req_ready_a` 1 cycle after valid; `eng_s_vi` pulses 3 cycles with the same values; `rsp_valid_a` with `rsp_max_addr`=15, `rsp_max`=28, `rsp_min`=6, `rsp_ovf`=0.
- `req_valid_a` and `req_valid_b` rise in the same cycle from reset → A is served first and `req_ready_b` stays 0; after A's handshake, B is granted; a second A+B collision grants B first.
- B sends 16 beats with `req_last` never set → burst ends after beat 16 with `rsp_ovf`=1; a 17th beat is not accepted until a new grant.
- Hold `rsp_ready_a`=0 for 10 cycles in RESP → `rsp_valid_a` and the result bus remain stable, `req_ready_b` stays 0, and `busy` stays 1.
- Assert `rst` after 2 beats of a burst → next cycle `busy`=0, `eng_s_vi`=0, no `rsp_valid`; a fresh A burst afterwards completes normally.
- With `MINMAX_ARB_TIMEOUT_EN` and `eng_vo` tied 0 → `rsp_valid` after `TO_CYCLES` cycles in RUN with `rsp_err`=1 and all-zero results.
